dds_lut_reader: RTL and testbench

- Direct-digital-synthesis read stage. Sits downstream of the true dual-port waveform RAM and owns its read port B.
- Runs a phase accumulator and turns the accumulator top bits plus a phase offset into RAM addresses.
- Returns the looked-up samples through a valid/ready stream.
- A credit-limited output FIFO absorbs the RAM read latency, so downstream stalls never drop or duplicate a sample.

---
 rtl/dds_lut_reader.sv | 166 ++++++++++++++++
 tb/tb_dds_lut_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dds_lut_reader.sv
// dds_lut_reader
//   DDS read stage. Steps a phase accumulator and turns its top ADDR_W bits
//   plus a phase offset into read addresses on port B of the waveform RAM.
//   The looked-up samples leave on a valid/ready stream.
//   Reads are issued only while the skid FIFO has room for every read still
//   in flight, so a downstream stall never drops or duplicates a sample.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start / stop         one-cycle pulses; stop wins when both are high
//   fword, pword         tuning word and phase offset (in LUT entries)
//   fword_upd            capture fword/pword into shadow; applied on next wrap
//   ram_web/ram_dinb     port B write side, tied off
//   ram_addrb/ram_doutb  port B read address (registered) / read data
//   sample, sample_valid, sample_ready   output stream
//   busy                 high outside IDLE
//   wrap                 one-cycle pulse on accumulator carry-out
module dds_lut_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_DEPTH  = 256,
  parameter int PHASE_WIDTH = 32,
  parameter int RAM_LATENCY = 1,
  localparam int ADDR_W     = $clog2(DATA_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PHASE_WIDTH-1:0] fword,
  input  logic [ADDR_W-1:0]      pword,
  input  logic                   fword_upd,
  output logic                   ram_web,
  output logic [ADDR_W-1:0]      ram_addrb,
  output logic [DATA_WIDTH-1:0]  ram_dinb,
  input  logic [DATA_WIDTH-1:0]  ram_doutb,
  output logic [DATA_WIDTH-1:0]  sample,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   busy,
  output logic                   wrap
);

  localparam int FIFO_DEPTH = RAM_LATENCY + 2;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state;
  logic [PHASE_WIDTH-1:0]  acc, fw_act, fw_sh, acc_sum;
  logic [ADDR_W-1:0]       pw_act, pw_sh;
  logic                    pend, carry;

  // vld_pipe[0] rides with ram_addrb; vld_pipe[RAM_LATENCY] lines up with ram_doutb
  logic [RAM_LATENCY:0]    vld_pipe;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        fifo_cnt;

  logic exit_vld, out_free, from_fifo, pop, push, start_go, credit, issue;
  int   occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ram_web  = 1'b0;
  assign ram_dinb = '0;
  assign busy     = (state != IDLE);

  assign {carry, acc_sum} = {1'b0, acc} + {1'b0, fw_act};

  assign exit_vld  = vld_pipe[RAM_LATENCY];
  assign out_free  = !sample_valid || sample_ready;
  assign from_fifo = (fifo_cnt != '0);
  // Output register takes the FIFO head, or the arriving read directly when
  // the FIFO is empty (keeps first-sample latency at RAM_LATENCY+1).
  assign pop       = out_free && (from_fifo || exit_vld);
  assign push      = exit_vld && !(pop && !from_fifo);

  // Every in-flight read must have a FIFO slot waiting for it.
  assign occ       = $countones(vld_pipe) + int'(fifo_cnt);
  assign credit    = (occ - int'(pop)) < FIFO_DEPTH;

  assign start_go  = (state == IDLE) && start && !stop;
  // At start the pipeline is empty, so the first read always has credit.
  assign issue     = start_go || ((state == RUN) && !stop && credit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      fw_act    <= '0;
      pw_act    <= '0;
      fw_sh     <= '0;
      pw_sh     <= '0;
      pend      <= 1'b0;
      ram_addrb <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        IDLE: if (start_go) begin
          // acc restarts at 0: first address is pword, next acc is fword
          acc       <= fword;
          fw_act    <= fword;
          pw_act    <= pword;
          pend      <= 1'b0;
          ram_addrb <= pword;
          state     <= RUN;
        end
        RUN: begin
          if (fword_upd) begin
            fw_sh <= fword;
            pw_sh <= pword;
            pend  <= 1'b1;
          end
          if (issue) begin
            ram_addrb <= acc[PHASE_WIDTH-1 -: ADDR_W] + pw_act;
            acc       <= acc_sum;
            if (carry) begin
              wrap <= 1'b1;
              // retune lands on the wrap; an update arriving this same edge stays pending
              if (pend) begin
                fw_act <= fw_sh;
                pw_act <= pw_sh;
                pend   <= fword_upd;
              end
            end
          end
          if (stop) state <= DRAIN;
        end
        DRAIN: if (vld_pipe == '0 && fifo_cnt == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[RAM_LATENCY-1:0], issue};
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop && from_fifo) rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop && from_fifo);
      if (pop) begin
        sample       <= from_fifo ? fifo_mem[rd_ptr] : ram_doutb;
        sample_valid <= 1'b1;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_doutb;
  end

endmodule

// File: tb/tb_dds_lut_reader.sv
// tb_dds_lut_reader
//   Bench for dds_lut_reader with a 1-cycle RAM model. The reference model
//   steps an arithmetic phase accumulator once per delivered sample, so the
//   expected stream does not depend on stall timing.
module tb_dds_lut_reader;
  localparam int DW = 8, DD = 256, PW = 32, AW = 8, LAT = 1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, fword_upd = 1'b0, sample_ready = 1'b0;
  logic [PW-1:0] fword = '0;
  logic [AW-1:0] pword = '0;
  logic          ram_web, sample_valid, busy, wrap;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_dinb, ram_doutb, sample;
  logic [DW-1:0] mem [DD];

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  dds_lut_reader #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .PHASE_WIDTH(PW), .RAM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .fword(fword), .pword(pword),
    .fword_upd(fword_upd), .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dinb(ram_dinb),
    .ram_doutb(ram_doutb), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .wrap(wrap)
  );

  // waveform RAM port B, one cycle read latency
  always @(posedge clk) ram_doutb <= mem[ram_addrb];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---- reference model: phase accumulator in plain 64-bit arithmetic ----
  logic [PW-1:0] m_acc, m_fw, m_fw_sh;
  logic [AW-1:0] m_pw, m_pw_sh;
  logic          m_pend;
  int            m_wraps, d_wraps, n_rx;

  task automatic model_next(output logic [AW-1:0] a);
    logic [63:0] s;
    a = AW'((m_acc / (2**(PW-AW))) + m_pw);
    s = {32'd0, m_acc} + {32'd0, m_fw};
    m_acc = s[PW-1:0];
    if (s >= 64'h1_0000_0000) begin
      m_wraps++;
      if (m_pend) begin
        m_fw   = m_fw_sh;
        m_pw   = m_pw_sh;
        m_pend = 1'b0;
      end
    end
  endtask

  // ---- output monitor ----
  bit            mon_en = 1'b0;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] held;
  logic [AW-1:0] mon_a;

  always @(negedge clk) begin
    if (mon_en) begin
      if (wrap) d_wraps++;
      if (hold_prev) chk("hold", {sample_valid, sample}, {1'b1, held});
      if (sample_valid && sample_ready) begin
        model_next(mon_a);
        chk("sample", sample, mem[mon_a]);
        n_rx++;
      end
      hold_prev = sample_valid && !sample_ready;
      held      = sample;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---- stimulus helpers ----
  task automatic cyc(input bit rnd);
    @(posedge clk); #1;
    sample_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic start_run(input logic [PW-1:0] fw, input logic [AW-1:0] pw);
    m_acc = '0; m_fw = fw; m_pw = pw; m_pend = 1'b0;
    m_wraps = 0; d_wraps = 0; n_rx = 0; mon_en = 1'b1;
    fword = fw; pword = pw; start = 1'b1; sample_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_rx(input int target, input bit rnd);
    for (int i = 0; i < 5000 && n_rx < target; i++) cyc(rnd);
    chk("rx_count", n_rx, target);
  endtask

  task automatic stop_drain();
    int n0;
    stop = 1'b1;
    cyc(0);
    stop = 1'b0;
    for (int i = 0; i < 50 && busy; i++) cyc(0);
    chk("drain_busy", busy, 0);
    for (int i = 0; i < 3; i++) cyc(0);
    n0 = n_rx;
    for (int i = 0; i < 5; i++) cyc(0);
    chk("drain_quiet", n_rx, n0);
    chk("drain_valid", sample_valid, 0);
    chk("wraps", d_wraps, m_wraps);
  endtask

  logic [AW-1:0] a_frz;

  initial begin
    for (int i = 0; i < DD; i++) mem[i] = DW'((i + 100) % 256);

    // reset values
    @(negedge clk);
    chk("rst_web", ram_web, 0);
    chk("rst_addr", ram_addrb, 0);
    chk("rst_din", ram_dinb, 0);
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0);

    // run A: ramp, latency, retune, deterministic stall, random stalls
    m_acc = '0; m_fw = 32'h0100_0000; m_pw = '0; m_pend = 1'b0;
    m_wraps = 0; d_wraps = 0; n_rx = 0; mon_en = 1'b1;
    fword = 32'h0100_0000; pword = '0; start = 1'b1; sample_ready = 1'b1;
    @(posedge clk); #1;             // edge N
    start = 1'b0;
    @(negedge clk);
    chk("busy_run", busy, 1);
    chk("lat_n0", sample_valid, 0);
    @(negedge clk);
    chk("lat_n1", sample_valid, 0);
    @(negedge clk);
    chk("lat_n2", sample_valid, 1);
    @(posedge clk); #1;

    wait_rx(50, 0);
    fword = 32'h0200_0000; pword = '0; fword_upd = 1'b1;
    m_fw_sh = 32'h0200_0000; m_pw_sh = '0; m_pend = 1'b1;
    cyc(0);
    fword_upd = 1'b0;
    for (int i = 0; i < 8; i++) cyc(0);

    sample_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) a_frz = ram_addrb;
      if (k > 2) chk("addr_frozen", ram_addrb, a_frz);
    end
    cyc(0);

    wait_rx(400, 1);
    stop_drain();

    // run B: step 2 with offset 10, random stalls; restart from idle
    start_run(32'h0200_0000, 8'd10);
    wait_rx(300, 1);
    stop_drain();

    // run C: reset mid-run
    start_run(32'h0100_0000, 8'd5);
    wait_rx(30, 1);
    #2;
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("mid_rst_addr", ram_addrb, 0);
    chk("mid_rst_sample", sample, 0);
    chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wrap", wrap, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(0);
    chk("post_rst_valid", sample_valid, 0);
    chk("post_rst_busy", busy, 0);

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    cyc(0);
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0);
    chk("startstop_busy", busy, 0);
    chk("startstop_valid", sample_valid, 0);

    // run D: fresh start after reset begins at pword
    start_run(32'h0100_0000, 8'd200);
    wait_rx(20, 0);
    stop_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
